// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and the light type used by the
// traffic-light controller and its independent safety monitor.
package traffic_pkg;

  typedef logic [2:0] light_t;

  // Bit 2 = red, bit 1 = yellow, bit 0 = green.
  localparam light_t LT_RED = 3'b100;
  localparam light_t LT_YEL = 3'b010;
  localparam light_t LT_GRN = 3'b001;

  // A lower value has higher priority when several faults fire together.
  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_ENCODING  = 3'd1,
    FLT_CONFLICT  = 3'd2,
    FLT_SEQUENCE  = 3'd3,
    FLT_SHORT_YEL = 3'd4,
    FLT_STARVE    = 3'd5
  } fault_code_t;

  function automatic logic light_is_onehot(input light_t l);
    return (l == LT_RED) || (l == LT_YEL) || (l == LT_GRN);
  endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-direction phase tracker: remembers the last legal lamp and the yellow
// run length, and flags encoding, sequence and short-yellow violations.
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  light_t light_i,
  output logic   enc_err_o,
  output logic   seq_err_o,
  output logic   short_yel_o,
  output logic   is_red_o,
  output logic   is_grn_o
);

  // YELLOW_MIN must be at least 1 so the dwell counter has a width.
  localparam int DW = $clog2(YELLOW_MIN + 1);
  localparam logic [DW-1:0] YMIN = DW'(YELLOW_MIN);

  light_t          prev_q, prev_d;
  logic [DW-1:0]   ydwell_q, ydwell_d;
  logic            enc_err;
  logic            seq_err;
  logic            short_yel;

  always_comb begin
    enc_err   = !light_is_onehot(light_i);
    seq_err   = 1'b0;
    short_yel = 1'b0;
    if (!enc_err) begin
      case (prev_q)
        LT_RED: seq_err = (light_i == LT_YEL);
        LT_GRN: seq_err = (light_i == LT_RED);
        LT_YEL: begin
          seq_err   = (light_i == LT_GRN);
          short_yel = (light_i == LT_RED) && (ydwell_q < YMIN);
        end
        default: seq_err = 1'b0;
      endcase
    end

    // A malformed sample resynchronises the tracker to red so that the
    // following samples are judged against a known phase.
    prev_d   = enc_err ? LT_RED : light_i;
    ydwell_d = '0;
    if (!enc_err && (light_i == LT_YEL)) begin
      ydwell_d = (ydwell_q == YMIN) ? ydwell_q : ydwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= LT_RED;
      ydwell_q <= '0;
    end else begin
      prev_q   <= prev_d;
      ydwell_q <= ydwell_d;
    end
  end

  assign enc_err_o   = enc_err;
  assign seq_err_o   = seq_err;
  assign short_yel_o = short_yel;
  assign is_red_o    = (light_i == LT_RED);
  assign is_grn_o    = (light_i == LT_GRN);

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor for the traffic-light controller outputs: checks lamp rules
// each cycle, latches the first fault code and counts violating cycles.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 3,
  parameter int MAX_WAIT   = 32,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c,
  input  logic [2:0]       light_farm,
  input  logic [2:0]       light_highway,
  input  logic             clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] fault_count
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic farm_enc, farm_seq, farm_short, farm_red, farm_grn;
  logic hwy_enc, hwy_seq, hwy_short, hwy_red;

  light_seq_checker #(.YELLOW_MIN(YELLOW_MIN)) u_farm_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .light_i     (light_farm),
    .enc_err_o   (farm_enc),
    .seq_err_o   (farm_seq),
    .short_yel_o (farm_short),
    .is_red_o    (farm_red),
    .is_grn_o    (farm_grn)
  );

  light_seq_checker #(.YELLOW_MIN(YELLOW_MIN)) u_hwy_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .light_i     (light_highway),
    .enc_err_o   (hwy_enc),
    .seq_err_o   (hwy_seq),
    .short_yel_o (hwy_short),
    .is_red_o    (hwy_red),
    .is_grn_o    ()
  );

  logic [WW-1:0]    wait_q, wait_d;
  logic             starve;
  logic             conflict;
  fault_code_t      code_now;
  logic             viol;

  logic             fault_q, fault_d;
  fault_code_t      code_q, code_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wait_d = '0;
    if (c && !farm_grn) begin
      wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
    end
    // Flags on the cycle the wait reaches the limit and every cycle it stays there.
    starve   = (wait_d == WMAX);
    conflict = !farm_red && !hwy_red;

    if (farm_enc || hwy_enc)             code_now = FLT_ENCODING;
    else if (conflict)                   code_now = FLT_CONFLICT;
    else if (farm_seq || hwy_seq)        code_now = FLT_SEQUENCE;
    else if (farm_short || hwy_short)    code_now = FLT_SHORT_YEL;
    else if (starve)                     code_now = FLT_STARVE;
    else                                 code_now = FLT_NONE;
    viol = (code_now != FLT_NONE);
  end

  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    count_d = count_q;
    if (clr) begin
      // A violation in the clearing cycle is recorded as a fresh first fault.
      fault_d = viol;
      code_d  = code_now;
      count_d = viol ? CNT_W'(1) : '0;
    end else if (viol) begin
      if (!fault_q) begin
        fault_d = 1'b1;
        code_d  = code_now;
      end
      count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
      count_q <= '0;
    end else begin
      wait_q  <= wait_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed and randomized bench for traffic_light_monitor against a
// rule-level reference model of the intersection checks.
module tb_traffic_light_monitor;

  localparam int YELLOW_MIN = 3;
  localparam int MAX_WAIT   = 32;
  localparam int CNT_W      = 8;
  localparam int W          = 4 + CNT_W;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             c   = 1'b0;
  logic             clr = 1'b0;
  logic [2:0]       lf  = R;
  logic [2:0]       lh  = R;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] fault_count;

  traffic_light_monitor #(
    .YELLOW_MIN (YELLOW_MIN),
    .MAX_WAIT   (MAX_WAIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .c             (c),
    .light_farm    (lf),
    .light_highway (lh),
    .clr           (clr),
    .fault         (fault),
    .fault_code    (fault_code),
    .fault_count   (fault_count)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: expected {fault, code, count} per clock step
  logic [W-1:0] exp_q[$];

  // reference model state; index 0 = farm, 1 = highway; phases 0=R 1=Y 2=G
  int m_prev[2];
  int m_yrun[2];
  int m_wait;
  int m_fault;
  int m_code;
  int m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int phase_of(input logic [2:0] l);
    if (l == R) return 0;
    if (l == Y) return 1;
    if (l == G) return 2;
    return -1;
  endfunction

  function automatic bit legal_move(input int p, input int n);
    return (n == p) || (p == 0 && n == 2) || (p == 2 && n == 1) || (p == 1 && n == 0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = 0;
      m_yrun[d] = 0;
    end
    m_wait  = 0;
    m_fault = 0;
    m_code  = 0;
    m_count = 0;
  endtask

  task automatic model_cycle(input logic cc, input logic [2:0] f, input logic [2:0] h,
                             input logic cl);
    int ph[2];
    int code;
    bit enc, conf, seq, shrt, starve;
    ph[0] = phase_of(f);
    ph[1] = phase_of(h);
    enc   = (ph[0] < 0) || (ph[1] < 0);
    conf  = (ph[0] != 0) && (ph[1] != 0);
    seq   = 0;
    shrt  = 0;
    for (int d = 0; d < 2; d++) begin
      if (ph[d] >= 0) begin
        if (!legal_move(m_prev[d], ph[d])) seq = 1;
        if (m_prev[d] == 1 && ph[d] == 0 && m_yrun[d] < YELLOW_MIN) shrt = 1;
      end
    end
    if (cc && ph[0] != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else                  m_wait = 0;
    starve = (m_wait == MAX_WAIT);

    code = enc ? 1 : conf ? 2 : seq ? 3 : shrt ? 4 : starve ? 5 : 0;

    for (int d = 0; d < 2; d++) begin
      if (ph[d] < 0) begin
        m_prev[d] = 0;
        m_yrun[d] = 0;
      end else begin
        m_prev[d] = ph[d];
        m_yrun[d] = (ph[d] == 1) ? m_yrun[d] + 1 : 0;
      end
    end

    if (cl) begin
      m_fault = (code != 0);
      m_code  = code;
      m_count = (code != 0) ? 1 : 0;
    end else if (code != 0) begin
      if (m_fault == 0) begin
        m_fault = 1;
        m_code  = code;
      end
      m_count = (m_count < (1 << CNT_W) - 1) ? m_count + 1 : m_count;
    end
    exp_q.push_back({1'(m_fault), 3'(m_code), CNT_W'(m_count)});
  endtask

  // driver: apply one sample, clock it, compare against the scoreboard
  task automatic step(input logic cc, input logic [2:0] f, input logic [2:0] h,
                      input logic cl);
    logic [W-1:0] e;
    c   = cc;
    lf  = f;
    lh  = h;
    clr = cl;
    model_cycle(cc, f, h, cl);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("step_fault", 32'(fault), 32'(e[W-1]));
    chk("step_code", 32'(fault_code), 32'(e[W-2 -: 3]));
    chk("step_count", 32'(fault_count), 32'(e[CNT_W-1:0]));
  endtask

  task automatic pick_lamp(input logic [2:0] cur, output logic [2:0] nxt);
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      nxt = 3'($urandom_range(0, 7));
    else if (r <= 3) begin
      case ($urandom_range(0, 2))
        0:       nxt = R;
        1:       nxt = Y;
        default: nxt = G;
      endcase
    end else     nxt = cur;
  endtask

  initial begin
    logic [2:0] rf, rh;
    model_reset();

    // reset state
    @(posedge clk);
    #1;
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_code", 32'(fault_code), 32'd0);
    chk("reset_count", 32'(fault_count), 32'd0);
    rst_n = 1'b1;

    // normal cycle: highway G x10, Y x3, R; farm G x5, Y x3, R; c pulsed
    step(0, R, R, 0);
    for (int i = 0; i < 10; i++) step(i >= 3 && i <= 6, R, G, 0);
    for (int i = 0; i < 3; i++) step(1, R, Y, 0);
    step(1, R, R, 0);
    for (int i = 0; i < 5; i++) step(i < 2, G, R, 0);
    for (int i = 0; i < 3; i++) step(0, Y, R, 0);
    step(0, R, R, 0);
    chk("normal_fault", 32'(fault), 32'd0);
    chk("normal_count", 32'(fault_count), 32'd0);

    // conflict, then sequence and short-yellow leave the first code in place
    step(0, R, G, 0);
    step(0, G, G, 0);
    chk("conflict_code", 32'(fault_code), 32'd2);
    chk("conflict_count", 32'(fault_count), 32'd1);
    step(0, R, G, 0);
    step(0, R, Y, 0);
    step(0, R, R, 0);
    chk("sticky_code", 32'(fault_code), 32'd2);
    chk("sticky_count", 32'(fault_count), 32'd3);

    // clear with no violation
    step(0, R, R, 1);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fault_code), 32'd0);
    chk("clr_count", 32'(fault_count), 32'd0);

    // green straight to red
    step(0, G, R, 0);
    step(0, R, R, 0);
    chk("seq_code", 32'(fault_code), 32'd3);

    // two-cycle yellow
    step(0, R, R, 1);
    step(0, G, R, 0);
    step(0, Y, R, 0);
    step(0, Y, R, 0);
    step(0, R, R, 0);
    chk("short_yel_code", 32'(fault_code), 32'd4);

    // malformed highway lamp while farm green: encoding beats conflict
    step(0, R, R, 1);
    step(0, G, R, 0);
    step(0, G, 3'b000, 0);
    chk("enc_code", 32'(fault_code), 32'd1);
    step(0, G, R, 0);
    chk("enc_resync_count", 32'(fault_count), 32'd1);
    for (int i = 0; i < 3; i++) step(0, Y, R, 0);
    step(0, R, R, 0);
    step(0, R, R, 1);

    // starvation then counter saturation
    for (int i = 0; i < MAX_WAIT - 1; i++) step(1, R, R, 0);
    chk("starve_not_yet", 32'(fault), 32'd0);
    step(1, R, R, 0);
    chk("starve_code", 32'(fault_code), 32'd5);
    chk("starve_count", 32'(fault_count), 32'd1);
    for (int i = 0; i < 260; i++) step(1, R, R, 0);
    chk("count_saturate", 32'(fault_count), 32'd255);

    // asynchronous reset in the middle of a fault
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_fault", 32'(fault), 32'd0);
    chk("async_rst_code", 32'(fault_code), 32'd0);
    chk("async_rst_count", 32'(fault_count), 32'd0);
    c = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, Y, R, 0);
    chk("yel_after_rst_code", 32'(fault_code), 32'd3);

    // randomized traffic
    step(0, R, R, 1);
    rf = R;
    rh = R;
    for (int i = 0; i < 300; i++) begin
      pick_lamp(rf, rf);
      pick_lamp(rh, rh);
      step(1'($urandom_range(0, 1)), rf, rh, ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent safety monitor on the receiving end of the `traffic_light` output interface. It samples `c`, `light_farm` and `light_highway` every cycle and checks them against the intersection rules:
- one-hot lamp encoding
- no conflicting right-of-way
- legal phase sequence
- minimum yellow dwell
- bounded wait for a waiting farm car

On the first violation it latches a sticky fault and code. It also keeps a saturating count of violating cycles. It sits beside the controller and drives the intersection's fail-safe flash logic.

## Interface
Parameters:
- `YELLOW_MIN`, 3: minimum consecutive yellow cycles before red.
- `MAX_WAIT`, 32: cycles `c`=1 may persist without farm green before starvation.
- `CNT_W`, 8: width of `fault_count`.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c`  in  1  farm-road car-present sensor, as seen by the controller.
- `light_farm`  in  3  farm lamps: [2]=red, [1]=yellow, [0]=green.
- `light_highway`  in  3  highway lamps, same encoding.
- `clr`  in  1  synchronous clear of `fault`, `fault_code` and `fault_count`.
- `fault`  out  1  sticky violation flag.
- `fault_code`  out  3  code of the first violation; 0 = none.
- `fault_count`  out  `CNT_W`  saturating count of cycles with any violation.

## Operation
- Per-direction phase tracking:
  - `prev` holds the previous sample, one register per direction; reset value RED (3'b100).
  - `ydwell` counts consecutive yellow cycles, saturating at `YELLOW_MIN`.
- Checks are evaluated on the current input against `prev`. Codes, in priority order (lowest wins when several fire in the same cycle):
  - 1 ENCODING: either input not exactly one-hot (000, 011, 111, …).
  - 2 CONFLICT: neither direction red.
  - 3 SEQUENCE: illegal transition in either direction. Legal transitions are R→R, R→G, G→G, G→Y, Y→Y, Y→R. Illegal are G→R, R→Y, Y→G.
  - 4 SHORT_YELLOW: Y→R with `ydwell` < `YELLOW_MIN`, in either direction.
  - 5 STARVATION: wait counter reaches `MAX_WAIT`.
- Starvation wait counter:
  - Increments while `c`=1 and farm is not green.
  - Clears when `c`=0 or farm is green.
  - Saturates at `MAX_WAIT` and keeps flagging every cycle until it clears.
- After a cycle flagged ENCODING, `prev` is forced to RED for the offending direction and `ydwell` clears. Subsequent checks therefore resynchronise rather than cascading SEQUENCE faults.
- Sticky latch: on the first violating cycle, `fault` is set and `fault_code` takes the winning code. Later violations do not change `fault_code`.
- `fault_count` increments on every violating cycle, including after `fault` is set, and saturates at all-ones.
- `clr`=1:
  - `fault`, `fault_code` and `fault_count` go to 0 at the next edge.
  - A violation in that same cycle wins: `fault`=1, new code, `fault_count`=1.
  - Phase trackers and the wait counter are unaffected.

## Timing
- All outputs are registered. A violation present on the inputs before edge k is visible on the outputs after edge k, i.e. 1-cycle latency.
- Reset (async assert, sync deassert expected upstream) sets:
  - `fault`=0, `fault_code`=0, `fault_count`=0
  - both `prev`=RED, `ydwell`=0, wait counter 0
- Reset mid-violation discards all history. The first cycle after reset compares against RED, so green or red is legal and yellow is a SEQUENCE fault.
- Inputs are sampled only on rising edges. Glitches between edges are not checked.

## Structure
- Shared package `traffic_pkg`:
  - lamp encodings `LT_RED`, `LT_YEL`, `LT_GRN`
  - fault code constants `FLT_NONE`…`FLT_STARVE`
  - the 3-bit light typedef
- Sub-module `light_seq_checker`, instantiated once per direction:
  - owns `prev` and `ydwell`
  - outputs `enc_err`, `seq_err`, `short_yel`, `is_red`, `is_grn`
- The top level holds the conflict check, starvation counter, priority encoder, sticky latch and `fault_count`.

## Test plan
- Reset, then normal cycle with `YELLOW_MIN`=3:
  - Stimulus: highway G×10, Y×3, R; farm R, then G×5, Y×3, R, with `c` pulsed.
  - Required: `fault`=0 and `fault_count`=0 throughout.
- Conflict:
  - Stimulus: farm G and highway G together for 1 cycle.
  - Required: `fault`=1 and `fault_code`=2 one cycle later; `fault_count`=1. A later SHORT_YELLOW leaves the code at 2 and increments the count.
- Sequence and dwell:
  - Stimulus: farm G→R directly.
  - Required: code 3.
  - Stimulus: after `clr`, farm G, Y×2, R.
  - Required: code 4.
- Encoding and priority:
  - Stimulus: `light_highway`=3'b000 while farm is green.
  - Required: code 1, not 2. The next cycle with highway R raises no new SEQUENCE fault.
- Starvation and saturation:
  - Stimulus: `c`=1 for 32 cycles with farm R.
  - Required: code 5 after the 32nd edge; `fault_count` increments each further cycle and stops at 255.
- Clear and reset:
  - Stimulus: `clr` with no violation.
  - Required: all outputs 0.
  - Stimulus: `rst_n` low mid-fault.
  - Required: outputs 0 immediately, without waiting for a clock edge.
  - Stimulus: farm yellow as the first sample after reset.
  - Required: code 3.
